// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: accepts a cipher key over a valid/ready
// handshake, starts the external expansion engine, captures the streamed
// round keys into a 15-entry store and reports when the schedule is usable.
// Reloading the key/length already held is a cache hit and skips expansion.
module aes_key_sched_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         core_busy,
  output logic         exp_start,
  output logic [255:0] exp_key,
  output logic [1:0]   exp_len,
  input  logic         exp_valid,
  input  logic [3:0]   exp_waddr,
  input  logic [127:0] exp_subkey,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data,
  output logic         rd_valid,
  output logic         keys_ready,
  output logic [3:0]   num_rounds,
  output logic         cache_hit,
  output logic         err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  // Number of rounds for a key length code; illegal length maps to 0.
  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      2'b01:   return 4'd10;
      2'b10:   return 4'd12;
      2'b11:   return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Indices 0..nr that must be valid for a complete schedule.
  function automatic logic [14:0] need_mask(input logic [3:0] nr);
    logic [14:0] m;
    m = '0;
    for (int i = 0; i < 15; i++) begin
      if (4'(i) <= nr) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [255:0]     key_q, key_d;
  logic [1:0]       len_q, len_d;
  logic [14:0]      valid_q, valid_d;
  logic             err_q, err_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     mem_q [0:14];

  logic [3:0]  nr;
  logic        accept;
  logic        is_hit;
  logic        wr_en;
  logic [14:0] wr_mask;
  logic [14:0] need;
  logic [15:0] valid_ext;

  // Handshake, hit detection and store-write decode.
  always_comb begin
    nr        = nr_of(len_q);
    need      = need_mask(nr);
    key_ready = ((state_q == S_IDLE) || (state_q == S_READY) || (state_q == S_ERROR))
                && !core_busy;
    accept    = key_valid && key_ready;
    is_hit    = (state_q == S_READY) && (key_in == key_q) && (key_len == len_q);
    wr_en     = (state_q == S_WAIT) && exp_valid && (exp_waddr <= nr);
    wr_mask   = wr_en ? (15'd1 << exp_waddr) : 15'd0;
    valid_ext = {1'b0, valid_q};
  end

  // Controller next-state: accept decisions, expansion tracking, timeout.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    len_d   = len_q;
    valid_d = valid_q;
    err_d   = err_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (accept) begin
          if (key_len == 2'b00) begin
            valid_d = '0;
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else if (is_hit) begin
            hit_d = 1'b1;
          end else begin
            key_d   = key_in;
            len_d   = key_len;
            valid_d = '0;
            err_d   = 1'b0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // Completion counts a write landing in this same cycle.
        valid_d = valid_q | wr_mask;
        if ((valid_d & need) == need) begin
          state_d = S_READY;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and key/length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      len_q   <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Round-key store; contents need no reset since valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[exp_waddr] <= exp_subkey;
  end

  // Output drive.
  always_comb begin
    exp_start  = (state_q == S_START);
    keys_ready = (state_q == S_READY);
    exp_key    = key_q;
    exp_len    = len_q;
    num_rounds = nr;
    cache_hit  = hit_q;
    err        = err_q;
    rd_valid   = (rd_addr <= nr) && valid_ext[rd_addr];
    rd_data    = (rd_addr <= 4'd14) ? mem_q[rd_addr] : '0;
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: expected exp_start payloads and
// cache-hit pulses are queued at accept time and retired by a monitor; the
// round-key store is mirrored in a small model.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset, key_valid, key_ready, core_busy;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         exp_start, exp_valid;
  logic [255:0] exp_key;
  logic [1:0]   exp_len;
  logic [3:0]   exp_waddr, rd_addr, num_rounds;
  logic [127:0] exp_subkey, rd_data;
  logic         rd_valid, keys_ready, cache_hit, err;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_sched_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .key_len(key_len), .core_busy(core_busy),
    .exp_start(exp_start), .exp_key(exp_key), .exp_len(exp_len),
    .exp_valid(exp_valid), .exp_waddr(exp_waddr), .exp_subkey(exp_subkey),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .keys_ready(keys_ready), .num_rounds(num_rounds), .cache_hit(cache_hit), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model state
  bit           mvalid [16];
  logic [127:0] mmem   [16];
  logic [1:0]   mlen = 2'b00;
  logic [255:0] ckey = '0;
  logic [257:0] start_q [$];
  int           hits_pending = 0;
  int           pend [$];
  logic [257:0] e;

  function automatic int nr_m(input logic [1:0] l);
    case (l)
      2'b01:   return 10;
      2'b10:   return 12;
      2'b11:   return 14;
      default: return 0;
    endcase
  endfunction

  function automatic bit all_valid();
    for (int i = 0; i <= nr_m(mlen); i++) if (!mvalid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [127:0] sub_of(input int idx);
    if (ckey == K128 && idx == 10) return RK10;
    return {ckey[255:192] ^ 64'(idx), 64'(idx * 32'h01010101) ^ ckey[127:64]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = miss, 1 = hit, 2 = illegal length
  task automatic load(input logic [255:0] k, input logic [1:0] l, input int kind);
    bit got;
    got = 1'b0;
    key_in = k; key_len = l; key_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (key_ready) got = 1'b1;
      else step();
    end
    if (!got) chk("accept_wait", 0, 1);
    else if (kind == 1) hits_pending++;
    else begin
      clear_model();
      if (kind == 0) begin
        mlen = l; ckey = k;
        start_q.push_back({k, l});
      end
    end
    step();
    key_valid = 1'b0;
  endtask

  // Drive queued indices one per cycle; after each write edge keys_ready
  // must reflect whether the model now holds a complete schedule.
  task automatic deliver();
    int idx;
    while (pend.size() > 0) begin
      idx = pend.pop_front();
      exp_valid = 1'b1; exp_waddr = 4'(idx); exp_subkey = sub_of(idx);
      if (idx <= nr_m(mlen)) begin
        mmem[idx] = exp_subkey; mvalid[idx] = 1'b1;
      end
      step();
      exp_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("keys_ready_after_idx%0d", idx), keys_ready, all_valid());
    end
    step();
  endtask

  task automatic rd_check(input string tag);
    bit want;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      want = (a <= nr_m(mlen)) && mvalid[a];
      chk($sformatf("%s_rdv%0d", tag, a), rd_valid, want);
      if (want) chk($sformatf("%s_rdd%0d", tag, a), rd_data, mmem[a]);
    end
    step();
  endtask

  // Retire expected exp_start payloads and cache-hit pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_start) begin
        if (start_q.size() == 0) chk("spurious_exp_start", 1, 0);
        else begin
          e = start_q.pop_front();
          chk("exp_key", exp_key, e[257:2]);
          chk("exp_len", exp_len, e[1:0]);
        end
      end
      if (cache_hit) begin
        if (hits_pending == 0) chk("spurious_cache_hit", 1, 0);
        else begin
          hits_pending--;
          chk("hit_keys_ready", keys_ready, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_in = '0; key_len = '0; core_busy = 1'b1;
    exp_valid = 1'b0; exp_waddr = '0; exp_subkey = '0; rd_addr = '0;
    clear_model();
    step();
    chk("rst_key_ready_busy", key_ready, 0);
    core_busy = 1'b0;
    #1 chk("rst_key_ready_idle", key_ready, 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_exp_start", exp_start, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_cache_hit", cache_hit, 0);
    chk("rst_num_rounds", num_rounds, 0);
    chk("rst_exp_key", exp_key, 0);
    step();

    // 128-bit load, in-order indices
    load(K128, 2'b01, 0);
    @(negedge clk);
    chk("a_exp_start", exp_start, 1);
    step();
    for (int i = 0; i <= 10; i++) pend.push_back(i);
    deliver();
    chk("a_num_rounds", num_rounds, 10);
    rd_addr = 4'd10;
    #1 chk("a_rk10", rd_data, {128'h0, RK10});
    rd_check("a");

    // Cache hit
    load(K128, 2'b01, 1);
    @(negedge clk);
    chk("b_no_start", exp_start, 0);
    chk("b_keys_ready", keys_ready, 1);
    step();
    @(negedge clk);
    chk("b_hit_one_cycle", cache_hit, 0);
    step();

    // Same key, different length: miss
    load(K128, 2'b11, 0);
    @(negedge clk);
    chk("c_exp_start", exp_start, 1);
    chk("c_keys_ready_drop", keys_ready, 0);
    step();
    for (int i = 0; i <= 14; i++) pend.push_back(i);
    deliver();

    // 256-bit load, out-of-order with a spurious index 15
    load(K256, 2'b11, 0);
    @(negedge clk);
    chk("d_exp_start", exp_start, 1);
    step();
    pend.push_back(14);
    for (int i = 0; i <= 6; i++) pend.push_back(i);
    pend.push_back(15);
    for (int i = 7; i <= 13; i++) pend.push_back(i);
    deliver();
    chk("d_num_rounds", num_rounds, 14);
    rd_check("d");

    // Backpressure while READY
    core_busy = 1'b1;
    key_in = K192; key_len = 2'b10; key_valid = 1'b1;
    #1 chk("e_key_ready_busy", key_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("e_key_ready_held", key_ready, 0);
      chk("e_keys_ready", keys_ready, 1);
      chk("e_exp_key_kept", exp_key, K256);
      rd_addr = 4'd0;
      #1 chk("e_store_kept", rd_data, {128'h0, mmem[0]});
      step();
    end
    core_busy = 1'b0;
    #1 chk("e_key_ready_release", key_ready, 1);
    clear_model(); mlen = 2'b10; ckey = K192;
    start_q.push_back({K192, 2'b10});
    step();
    key_valid = 1'b0;
    @(negedge clk);
    chk("e_exp_start", exp_start, 1);
    step();

    // Timeout: only indices 0..5 arrive; WAIT entered at the previous edge
    for (int c = 0; c <= 64; c++) begin
      if (c < 6) begin
        exp_valid = 1'b1; exp_waddr = 4'(c); exp_subkey = sub_of(c);
      end else exp_valid = 1'b0;
      @(negedge clk);
      if (c == 3)  chk("f_num_rounds", num_rounds, 12);
      if (c == 63) chk("f_err_before", err, 0);
      if (c == 63) chk("f_key_ready_before", key_ready, 0);
      if (c == 64) chk("f_err_timeout", err, 1);
      if (c == 64) chk("f_key_ready_error", key_ready, 1);
      step();
    end
    exp_valid = 1'b0;

    // Next valid load clears err
    load(K128, 2'b01, 0);
    @(negedge clk);
    chk("g_err_cleared", err, 0);
    step();
    for (int i = 0; i <= 10; i++) pend.push_back(i);
    deliver();

    // Illegal length
    load(K192, 2'b00, 2);
    @(negedge clk);
    chk("h_err", err, 1);
    chk("h_no_start", exp_start, 0);
    chk("h_keys_ready", keys_ready, 0);
    chk("h_key_ready", key_ready, 1);
    rd_addr = 4'd0;
    #1 chk("h_valid_cleared", rd_valid, 0);
    step();

    // Reset during WAIT, then stray strobes
    load(K256, 2'b11, 0);
    @(negedge clk);
    chk("i_exp_start", exp_start, 1);
    step();
    for (int i = 0; i <= 3; i++) pend.push_back(i);
    deliver();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_model(); mlen = 2'b00;
    @(negedge clk);
    chk("i_keys_ready", keys_ready, 0);
    chk("i_num_rounds", num_rounds, 0);
    chk("i_err", err, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      exp_valid = 1'b1; exp_waddr = 4'(i); exp_subkey = 128'hdead;
      step();
      exp_valid = 1'b0;
      @(negedge clk);
      chk("i_strobe_keys_ready", keys_ready, 0);
      chk("i_strobe_key_ready", key_ready, 1);
    end
    step();

    chk("start_queue_drained", 256'(start_q.size()), 0);
    chk("hits_drained", 256'(hits_pending), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
